// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared encodings and code helper for the combination lock
package lock_pkg;

  localparam int          NDIG_DEF = 6;
  localparam logic [23:0] CODE_DEF = 24'h305464;

  typedef enum logic [3:0] {
    S0       = 4'd0,
    S1       = 4'd1,
    S2       = 4'd2,
    S3       = 4'd3,
    S4       = 4'd4,
    S5       = 4'd5,
    F1       = 4'd6,
    F2       = 4'd7,
    F3       = 4'd8,
    F4       = 4'd9,
    F5       = 4'd10,
    S_OPEN   = 4'd11,
    S_CLOSED = 4'd12
  } state_t;

  localparam logic [1:0] ST_ENTER  = 2'b00;
  localparam logic [1:0] ST_OPEN   = 2'b01;
  localparam logic [1:0] ST_CLOSED = 2'b10;

  // Nibble idx of the packed code; index 0 is the first digit entered (MS nibble).
  function automatic logic [3:0] code_nibble(input logic [23:0] code, input logic [2:0] idx);
    logic [23:0] w_sh;
    w_sh = code << {idx, 2'b00};
    return w_sh[23:20];
  endfunction

endpackage

// File: rtl/lock_fsm.sv
// rtl/lock_fsm.sv - sequential core of the combination lock, one digit per clk edge
module lock_fsm
  import lock_pkg::*;
#(
  parameter int          NDIG = NDIG_DEF,
  parameter logic [23:0] CODE = CODE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  output logic [3:0] last_digit,
  output logic       last_valid,
  output logic [2:0] count,
  output logic [1:0] status,
  output logic [3:0] dbg_state
);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_last_digit;
  logic       r_last_valid;
  logic [2:0] r_count;
  logic [1:0] r_status;
  logic       w_advance;
  logic       w_recover;
  logic       w_match;
  logic       w_last;
  logic [1:0] w_next_status;

  always_comb begin
    w_next_state  = r_state;
    w_advance     = 1'b0;
    w_recover     = 1'b0;
    w_match       = (digit == code_nibble(CODE, r_count));
    w_last        = (r_count == 3'(NDIG - 1));
    case (r_state)
      S0, S1, S2, S3, S4, S5: begin
        w_advance = 1'b1;
        if (w_match)
          w_next_state = w_last ? S_OPEN : state_t'(r_state + 4'd1);
        else
          w_next_state = w_last ? S_CLOSED : state_t'(4'(F1) + {1'b0, r_count});
      end
      F1, F2, F3, F4, F5: begin
        w_advance    = 1'b1;
        w_next_state = w_last ? S_CLOSED : state_t'(r_state + 4'd1);
      end
      S_OPEN, S_CLOSED: ;
      default: begin
        w_recover    = 1'b1;
        w_next_state = S0;
      end
    endcase
    w_next_status = (w_next_state == S_OPEN)   ? ST_OPEN :
                    (w_next_state == S_CLOSED) ? ST_CLOSED : ST_ENTER;
  end

  // Terminal states hold every register; only reset starts a new attempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S0;
      r_last_digit <= 4'd0;
      r_last_valid <= 1'b1;
      r_count      <= 3'd0;
      r_status     <= ST_ENTER;
    end else begin
      r_state <= w_next_state;
      if (w_advance) begin
        r_last_digit <= digit;
        r_last_valid <= (digit <= 4'd9);
        r_count      <= r_count + 3'd1;
        r_status     <= w_next_status;
      end else if (w_recover) begin
        r_count  <= 3'd0;
        r_status <= ST_ENTER;
      end
    end
  end

  assign last_digit = r_last_digit;
  assign last_valid = r_last_valid;
  assign count      = r_count;
  assign status     = r_status;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_lock_fsm.sv
// tb/tb_lock_fsm.sv - directed scoreboard bench for lock_fsm
module tb_lock_fsm;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit;
  logic [3:0] last_digit;
  logic       last_valid;
  logic [2:0] count;
  logic [1:0] status;
  logic [3:0] dbg_state;

  lock_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit      (digit),
    .last_digit (last_digit),
    .last_valid (last_valid),
    .count      (count),
    .status     (status),
    .dbg_state  (dbg_state)
  );

  typedef struct packed {
    logic [3:0] ld;
    logic       lv;
    logic [2:0] cnt;
    logic [1:0] st;
    logic [3:0] dbg;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks;
  int         n_fail;
  logic [3:0] code_digits [6] = '{4'd3, 4'd0, 4'd5, 4'd4, 4'd6, 4'd4};

  logic [3:0] m_last;
  logic       m_valid;
  int         m_count;
  logic       m_bad;
  logic       m_done;

  function automatic exp_t model_exp();
    exp_t e;
    e.ld  = m_last;
    e.lv  = m_valid;
    e.cnt = 3'(m_count);
    e.st  = m_done ? (m_bad ? 2'b10 : 2'b01) : 2'b00;
    if (m_done)
      e.dbg = m_bad ? 4'd12 : 4'd11;
    else
      e.dbg = m_bad ? 4'(5 + m_count) : 4'(m_count);
    return e;
  endfunction

  task automatic model_reset();
    m_last  = 4'd0;
    m_valid = 1'b1;
    m_count = 0;
    m_bad   = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic model_press(input logic [3:0] d);
    if (!m_done) begin
      m_last  = d;
      m_valid = (d <= 4'd9);
      if (d != code_digits[m_count]) m_bad = 1'b1;
      m_count = m_count + 1;
      if (m_count == 6) m_done = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s scoreboard empty observed=1 expected=0", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".last_digit"}, last_digit, e.ld);
    check({tag, ".last_valid"}, {3'd0, last_valid}, {3'd0, e.lv});
    check({tag, ".count"}, {1'b0, count}, {1'b0, e.cnt});
    check({tag, ".status"}, {2'd0, status}, {2'd0, e.st});
    check({tag, ".dbg_state"}, dbg_state, e.dbg);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    sb_q.push_back(model_exp());
    compare_pop(tag);
    rst_n = 1'b1;
    #2;
  endtask

  task automatic press(input string tag, input logic [3:0] d);
    digit = d;
    #1;
    model_press(d);
    sb_q.push_back(model_exp());
    clk = 1'b1;
    #2;
    compare_pop(tag);
    #3;
    clk = 1'b0;
    #4;
  endtask

  task automatic press_seq(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3,
                           input logic [3:0] d4, input logic [3:0] d5);
    press({tag, "_p1"}, d0);
    press({tag, "_p2"}, d1);
    press({tag, "_p3"}, d2);
    press({tag, "_p4"}, d3);
    press({tag, "_p5"}, d4);
    press({tag, "_p6"}, d5);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk      = 1'b0;
    digit    = 4'd0;
    rst_n    = 1'b1;
    #3;

    do_reset("reset_initial");
    press_seq("good", 4'd3, 4'd0, 4'd5, 4'd4, 4'd6, 4'd4);
    press("after_open_1", 4'd7);
    press("after_open_2", 4'd7);
    press("after_open_3", 4'd7);

    do_reset("reset_b");
    press_seq("bad_last", 4'd3, 4'd0, 4'd5, 4'd4, 4'd6, 4'd5);
    press("after_closed", 4'd3);

    do_reset("reset_c");
    press_seq("bad_first", 4'd1, 4'd0, 4'd5, 4'd4, 4'd6, 4'd4);

    do_reset("reset_d");
    press_seq("invalid", 4'd3, 4'hC, 4'd5, 4'd4, 4'd6, 4'd4);

    do_reset("reset_e");
    press("mid_p1", 4'd3);
    press("mid_p2", 4'd0);
    press("mid_p3", 4'd5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    sb_q.push_back(model_exp());
    compare_pop("async_reset_no_edge");
    #2;
    rst_n = 1'b1;
    #2;
    press_seq("after_async", 4'd3, 4'd0, 4'd5, 4'd4, 4'd6, 4'd4);

    do_reset("reset_f");
    press("pre_same_p1", 4'd3);
    press("pre_same_p2", 4'd0);
    digit = 4'd5;
    #1;
    rst_n = 1'b0;
    clk   = 1'b1;
    #2;
    model_reset();
    sb_q.push_back(model_exp());
    compare_pop("reset_same_edge");
    clk = 1'b0;
    #2;
    rst_n = 1'b1;
    #2;
    press("post_same_p1", 4'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
